// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 line port between I-side (read) and D-side (read/write) L1 caches
// Ports: clk; rst (async, active-low); i_* I-side request/response; d_* D-side request/response;
//   l2_* registered request to L2 plus l2_rdata256/l2_resp coming back.
// Macro L2_ARB_RR_EN: round-robin arbitration instead of fixed D priority with WAIT_LIMIT guard.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int WAIT_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata256,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata256,
  output logic [LINE_W-1:0] d_rdata256,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata256,
  input  logic [LINE_W-1:0] l2_rdata256,
  input  logic              l2_resp
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t state, state_nx;
  logic grant_i, grant_d, idle;
  assign idle = state == IDLE;
`ifdef L2_ARB_RR_EN
  logic rr_last;
  // rr_last = 1 means D was granted last, so I wins the next tie
  assign grant_d = (d_read | d_write) & (!i_read | !rr_last);
  always_ff @(posedge clk or negedge rst)
    if (!rst) rr_last <= 1'b1;
    else if (idle && (grant_i | grant_d)) rr_last <= grant_d;
`else
  logic [3:0] wait_cnt;
  assign grant_d = (d_read | d_write) & (!i_read | wait_cnt != 4'(WAIT_LIMIT));
  always_ff @(posedge clk or negedge rst)
    if (!rst) wait_cnt <= '0;
    else if (!i_read || (idle && grant_i)) wait_cnt <= '0;
    else if (idle && grant_d && wait_cnt != 4'(WAIT_LIMIT)) wait_cnt <= wait_cnt + 4'd1;
`endif
  assign grant_i = i_read & !grant_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (idle) state_nx = grant_d ? GRANT_D : grant_i ? GRANT_I : IDLE;
    else if (l2_resp) state_nx = IDLE;
  end
  // simultaneous d_read/d_write is forwarded as a write only
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      l2_address  <= '0;
      l2_read     <= 1'b0;
      l2_write    <= 1'b0;
      l2_wdata256 <= '0;
    end else if (idle && (grant_i | grant_d)) begin
      l2_address  <= grant_d ? d_address : i_address;
      l2_read     <= grant_i | !d_write;
      l2_write    <= grant_d & d_write;
      l2_wdata256 <= (grant_d & d_write) ? d_wdata256 : '0;
    end else if (!idle && l2_resp) begin
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
    end
  assign i_resp     = state == GRANT_I && l2_resp;
  assign d_resp     = state == GRANT_D && l2_resp;
  assign i_rdata256 = state == GRANT_I ? l2_rdata256 : '0;
  assign d_rdata256 = state == GRANT_D ? l2_rdata256 : '0;
endmodule
